cnu_serial: RTL and testbench

CNU_SERIAL -- requirements
Module: cnu_serial

---
 rtl/cnu_serial.sv | 116 +++++++++++
 tb/tb_cnu_serial.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnu_serial.sv
// Serial min-sum check-node unit: collects DEG variable-to-check messages, then
// emits DEG check-to-variable messages using min1/min2/idx and the sign product.
module cnu_serial #(
  parameter int DEG = 4,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] q_in,
  input  logic         q_valid,
  output logic         q_ready,
  output logic [W-1:0] r_out,
  output logic         r_valid,
  input  logic         r_ready,
  output logic         r_last,
  output logic         parity_ok,
  output logic         dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and held data stays stable.
  localparam int KW = (DEG > 1) ? $clog2(DEG) : 1;
  localparam logic [KW-1:0] LAST   = KW'(DEG - 1);
  localparam logic [W-1:0]  MAXMAG = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MOSTNEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  state_t         state;
  logic [KW-1:0]  k;
  logic [KW-1:0]  j;
  logic [W-1:0]   min1;
  logic [W-1:0]   min2;
  logic [KW-1:0]  idx;
  logic [DEG-1:0] signs;

  logic [W-1:0] q_mag;
  logic [W-1:0] sel_mag;
  logic         sel_neg;
  logic         sign_prod;

  // The most negative input has no positive counterpart, so it saturates.
  always_comb begin
    q_mag = q_in;
    if (q_in == MOSTNEG)
      q_mag = MAXMAG;
    else if (q_in[W-1])
      q_mag = -q_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COLLECT;
      k     <= '0;
      j     <= '0;
      min1  <= MAXMAG;
      min2  <= MAXMAG;
      idx   <= '0;
      signs <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (q_valid) begin
            signs[k] <= q_in[W-1];
            if (q_mag < min1) begin
              min2 <= min1;
              min1 <= q_mag;
              idx  <= k;
            end else if (q_mag < min2) begin
              min2 <= q_mag;
            end
            if (k == LAST) begin
              k     <= '0;
              state <= EMIT;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        EMIT: begin
          if (r_ready) begin
            if (j == LAST) begin
              j     <= '0;
              state <= COLLECT;
              min1  <= MAXMAG;
              min2  <= MAXMAG;
              idx   <= '0;
              signs <= '0;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Edge j excludes its own contribution: the owner of min1 gets min2, and
  // XOR-ing s_j back out of the full product leaves the product of the others.
  always_comb begin
    sign_prod = ^signs;
    sel_mag   = (j == idx) ? min2 : min1;
    sel_neg   = sign_prod ^ signs[j];
    r_out     = '0;
    if (state == EMIT && sel_mag != '0)
      r_out = sel_neg ? -sel_mag : sel_mag;
  end

  assign q_ready   = (state == COLLECT);
  assign r_valid   = (state == EMIT);
  assign r_last    = (state == EMIT) && (j == LAST);
  assign parity_ok = ~sign_prod;
  assign dbg_state = state;

endmodule

// File: tb/tb_cnu_serial.sv
// Bench for cnu_serial: directed vector table, reset corner sequences, and
// randomized checks against an exclude-self min-sum reference model.
module tb_cnu_serial;
  localparam int DEG = 4;
  localparam int W   = 32;
  localparam logic [W-1:0] MAXMAG  = 32'h7fff_ffff;
  localparam logic [W-1:0] MOSTNEG = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] q_in = '0;
  logic         q_valid = 1'b0;
  logic         q_ready;
  logic [W-1:0] r_out;
  logic         r_valid;
  logic         r_ready = 1'b0;
  logic         r_last;
  logic         parity_ok;
  logic         dbg_state;

  cnu_serial #(.DEG(DEG), .W(W)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .q_valid(q_valid), .q_ready(q_ready),
    .r_out(r_out), .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
    .parity_ok(parity_ok), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DEG-1:0][W-1:0] q;
    logic [DEG-1:0][W-1:0] r;
    logic                  par;
  } vec_t;

  vec_t         vecs[4];
  logic [W-1:0] exp_q[$];
  logic         exp_par;
  logic [W-1:0] cur_q[DEG];
  int           checks = 0;
  int           failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int n, input logic [W-1:0] q0, q1, q2, q3,
                         input logic [W-1:0] r0, r1, r2, r3, input logic par);
    vecs[n].q[0] = q0; vecs[n].q[1] = q1; vecs[n].q[2] = q2; vecs[n].q[3] = q3;
    vecs[n].r[0] = r0; vecs[n].r[1] = r1; vecs[n].r[2] = r2; vecs[n].r[3] = r3;
    vecs[n].par = par;
  endtask

  task automatic load_vec(input int n);
    for (int i = 0; i < DEG; i++) begin
      cur_q[i] = vecs[n].q[i];
      exp_q.push_back(vecs[n].r[i]);
    end
    exp_par = vecs[n].par;
  endtask

  function automatic logic [W-1:0] sat_mag(input logic [W-1:0] v);
    if (v == MOSTNEG) return MAXMAG;
    if (v[W-1]) return -v;
    return v;
  endfunction

  // Each output is the minimum magnitude and sign product over all other edges.
  task automatic model_check;
    logic [W-1:0] m;
    logic         s;
    logic         all_s;
    all_s = 1'b0;
    for (int i = 0; i < DEG; i++) all_s ^= cur_q[i][W-1];
    for (int jj = 0; jj < DEG; jj++) begin
      m = MAXMAG;
      s = 1'b0;
      for (int i = 0; i < DEG; i++) begin
        if (i != jj) begin
          if (sat_mag(cur_q[i]) < m) m = sat_mag(cur_q[i]);
          s ^= cur_q[i][W-1];
        end
      end
      exp_q.push_back((m == '0) ? '0 : (s ? -m : m));
    end
    exp_par = ~all_s;
  endtask

  task automatic send_check(input int max_gap);
    for (int i = 0; i < DEG; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        q_valid = 1'b0;
        q_in = $urandom;
        tick();
      end
      q_valid = 1'b1;
      q_in = cur_q[i];
      chk("q_ready_collect", q_ready, 1);
      chk("r_valid_collect", r_valid, 0);
      tick();
      q_valid = 1'b0;
    end
    chk("first_r_valid_latency", r_valid, 1);
  endtask

  task automatic recv_check(input int max_stall);
    logic [W-1:0] e;
    for (int jj = 0; jj < DEG; jj++) begin
      repeat ($urandom_range(0, max_stall)) begin
        r_ready = 1'b0;
        q_valid = 1'b1;
        q_in = $urandom;
        chk("r_valid_stall", r_valid, 1);
        chk("r_out_stall", r_out, exp_q.size() > 0 ? exp_q[0] : '0);
        chk("q_ready_emit_stall", q_ready, 0);
        chk("r_last_stall", r_last, (jj == DEG - 1) ? 1 : 0);
        tick();
      end
      q_valid = 1'b0;
      r_ready = 1'b1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("r_valid", r_valid, 1);
      chk("r_out", r_out, e);
      chk("r_last", r_last, (jj == DEG - 1) ? 1 : 0);
      chk("parity_ok", parity_ok, exp_par);
      chk("q_ready_emit", q_ready, 0);
      tick();
      r_ready = 1'b0;
    end
    chk("r_valid_after_check", r_valid, 0);
    chk("q_ready_after_check", q_ready, 1);
  endtask

  initial begin
    set_vec(0, 32'd5, 32'hffff_fffd, 32'd7, 32'hffff_fff7,
            32'd3, 32'hffff_fffb, 32'd3, 32'hffff_fffd, 1'b1);
    set_vec(1, 32'd4, 32'd4, 32'hffff_fffc, 32'd4,
            32'hffff_fffc, 32'hffff_fffc, 32'd4, 32'hffff_fffc, 1'b0);
    // The saturated -2^31 is excluded from edges 0 by min1=10; edge 1 sees min2=20.
    set_vec(2, MOSTNEG, 32'd10, 32'd20, 32'd30,
            32'd10, 32'hffff_ffec, 32'hffff_fff6, 32'hffff_fff6, 1'b0);
    set_vec(3, 32'd0, 32'hffff_fffa, 32'd8, 32'd3,
            32'hffff_fffd, 32'd0, 32'd0, 32'd0, 1'b0);

    #12;
    chk("reset_r_valid", r_valid, 0);
    chk("reset_r_out", r_out, 0);
    chk("reset_r_last", r_last, 0);
    chk("reset_parity_ok", parity_ok, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("reset_q_ready", q_ready, 1);

    for (int n = 0; n < 4; n++) begin
      load_vec(n);
      send_check(0);
      recv_check(0);
    end

    // Gapped input and stalled output must give the same sequence.
    load_vec(0);
    send_check(2);
    recv_check(2);

    // Reset after two accepted inputs discards the partial check.
    for (int i = 0; i < 2; i++) begin
      q_valid = 1'b1;
      q_in = 32'hffff_ff00;
      tick();
    end
    q_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk("midcollect_rst_r_valid", r_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("midcollect_release_r_valid", r_valid, 0);
    load_vec(0);
    send_check(0);
    recv_check(0);

    // Reset in the middle of emitting drops the remaining outputs.
    for (int i = 0; i < DEG; i++) begin
      q_valid = 1'b1;
      q_in = vecs[1].q[i];
      tick();
    end
    q_valid = 1'b0;
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    #2 rst = 1'b0;
    #1 chk("midemit_rst_r_valid", r_valid, 0);
    chk("midemit_rst_r_out", r_out, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("midemit_release_r_valid", r_valid, 0);
    load_vec(0);
    send_check(0);
    recv_check(0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < DEG; i++) begin
        case ($urandom_range(0, 4))
          0: cur_q[i] = $urandom;
          1: cur_q[i] = W'($urandom_range(0, 16)) - 32'd8;
          2: cur_q[i] = MOSTNEG;
          3: cur_q[i] = ($urandom_range(0, 1) == 1) ? MAXMAG : '0;
          default: cur_q[i] = W'($urandom_range(0, 1000)) - 32'd500;
        endcase
      end
      model_check();
      send_check(2);
      recv_check(2);
    end

    chk("exp_q_drained", W'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
